bcd_value_editor: RTL and testbench

Button-driven editor for a multi-digit BCD setpoint. It takes the press pulses from five `pushbutton_detector` instances (up, down, left, right, center) and edits a working copy of the value digit by digit. On center it commits the result to a registered output. It runs on the fast system clock `clk`, downstream of the detectors. Their pulses come from the divided-clock domain and last many `clk` cycles, so every input is synchronized and edge-detected before use.

---
 rtl/bcd_value_editor_pkg.sv | 32 +++
 rtl/bcd_value_editor_pulse_edge.sv | 30 +++
 rtl/bcd_value_editor.sv | 92 +++++++++
 tb/tb_bcd_value_editor.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bcd_value_editor_pkg.sv
// bcd_value_editor_pkg: shared FSM states, BCD limits, button priority and digit helpers
package bcd_value_editor_pkg;

    localparam logic [0:0] ST_LOCKED = 1'b0;
    localparam logic [0:0] ST_EDIT   = 1'b1;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Bit index in the event vector doubles as priority: lower index wins.
    typedef enum logic [2:0] {
        BTN_CENTER = 3'd0,
        BTN_UP     = 3'd1,
        BTN_DOWN   = 3'd2,
        BTN_LEFT   = 3'd3,
        BTN_RIGHT  = 3'd4
    } btn_e;

    localparam int NUM_BTN = 5;

    // Keep only the lowest set bit, i.e. the highest-priority event.
    function automatic logic [NUM_BTN-1:0] first_event(input logic [NUM_BTN-1:0] ev);
        return ev & (~ev + NUM_BTN'(1));
    endfunction

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_value_editor_pulse_edge.sv
// bcd_value_editor_pulse_edge: 2-flop synchronizer plus rising-edge detector
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   din  : asynchronous level input
//   rise : one-cycle event per low-to-high transition of din
module bcd_value_editor_pulse_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1, s2, prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Driven only by flops, so no input reaches the outputs combinationally.
    assign rise = s2 & ~prev;

endmodule

// File: rtl/bcd_value_editor.sv
// bcd_value_editor: button-driven digit-by-digit editor for a BCD setpoint
//   clk, rst (async active-low)
//   btn_up/down/left/right/center : press pulses from the slow domain
//   work_value   : working copy being edited (digit 0 = bits [3:0])
//   commit_value : last committed value
//   cursor       : selected digit index
//   edit_mode    : high while editing
//   commit       : one-cycle strobe when commit_value updates
import bcd_value_editor_pkg::*;

module bcd_value_editor #(
    parameter int DIGITS = 4,
    parameter int CUR_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_center,
    output logic [4*DIGITS-1:0]   work_value,
    output logic [4*DIGITS-1:0]   commit_value,
    output logic [CUR_W-1:0]      cursor,
    output logic                  edit_mode,
    output logic                  commit
);

    logic [NUM_BTN-1:0]  raw, ev, act;
    logic [0:0]          state;
    logic [4*DIGITS-1:0] work_nxt;

    assign raw[BTN_CENTER] = btn_center;
    assign raw[BTN_UP]     = btn_up;
    assign raw[BTN_DOWN]   = btn_down;
    assign raw[BTN_LEFT]   = btn_left;
    assign raw[BTN_RIGHT]  = btn_right;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        bcd_value_editor_pulse_edge u_edge (
            .clk  (clk),
            .rst  (rst),
            .din  (raw[b]),
            .rise (ev[b])
        );
    end

    assign act = first_event(ev);

    // Only the digit under the cursor changes; no carry or borrow between digits.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] d;
        logic       sel;
        assign d   = work_value[4*g +: 4];
        assign sel = cursor == CUR_W'(g);
        assign work_nxt[4*g +: 4] = !sel           ? d :
                                    act[BTN_UP]    ? bcd_inc(d) :
                                    act[BTN_DOWN]  ? bcd_dec(d) : d;
    end

    assign edit_mode = state == ST_EDIT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_LOCKED;
            work_value   <= '0;
            commit_value <= '0;
            cursor       <= '0;
            commit       <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (state == ST_LOCKED) begin
                if (act[BTN_CENTER]) begin
                    state      <= ST_EDIT;
                    work_value <= commit_value;
                    cursor     <= '0;
                end
            end else if (act[BTN_CENTER]) begin
                state        <= ST_LOCKED;
                commit_value <= work_value;
                commit       <= 1'b1;
            end else if (act[BTN_UP] || act[BTN_DOWN]) begin
                work_value <= work_nxt;
            end else if (act[BTN_LEFT]) begin
                cursor <= (cursor == CUR_W'(DIGITS-1)) ? '0 : cursor + CUR_W'(1);
            end else if (act[BTN_RIGHT]) begin
                cursor <= (cursor == '0) ? CUR_W'(DIGITS-1) : cursor - CUR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_value_editor.sv
// tb_bcd_value_editor: directed self-checking bench for bcd_value_editor
module tb_bcd_value_editor;

    localparam logic [4:0] C = 5'b00001;
    localparam logic [4:0] U = 5'b00010;
    localparam logic [4:0] D = 5'b00100;
    localparam logic [4:0] L = 5'b01000;
    localparam logic [4:0] R = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  btns = '0;
    logic [15:0] work_value, commit_value;
    logic [1:0]  cursor;
    logic        edit_mode, commit;
    int          n_chk = 0, n_pass = 0, n_commit = 0, c0;

    bcd_value_editor #(.DIGITS(4), .CUR_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up       (btns[1]),
        .btn_down     (btns[2]),
        .btn_left     (btns[3]),
        .btn_right    (btns[4]),
        .btn_center   (btns[0]),
        .work_value   (work_value),
        .commit_value (commit_value),
        .cursor       (cursor),
        .edit_mode    (edit_mode),
        .commit       (commit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (commit) n_commit++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge clk) btns = m;
        repeat (3) @(negedge clk);
        btns = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_work", 32'(work_value), 32'h0);
        check("rst_commit_val", 32'(commit_value), 32'h0);
        check("rst_cursor", 32'(cursor), 32'h0);
        check("rst_edit", 32'(edit_mode), 32'h0);
        check("rst_commit", 32'(commit), 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        press(U); press(D); press(L); press(R);
        check("locked_work", 32'(work_value), 32'h0);
        check("locked_cursor", 32'(cursor), 32'h0);
        check("locked_edit", 32'(edit_mode), 32'h0);
        check("locked_no_commit", 32'(n_commit), 32'h0);

        press(C);
        check("enter_edit", 32'(edit_mode), 32'h1);
        press(U); press(U); press(U);
        check("up3", 32'(work_value), 32'h0003);
        press(L);
        check("left1", 32'(cursor), 32'h1);
        press(U); press(U);
        check("up2_d1", 32'(work_value), 32'h0023);
        press(C);
        check("commit_val", 32'(commit_value), 32'h0023);
        check("commit_once", 32'(n_commit), 32'h1);
        check("commit_exit", 32'(edit_mode), 32'h0);

        press(C);
        check("reenter_load", 32'(work_value), 32'h0023);
        check("reenter_cursor", 32'(cursor), 32'h0);
        press(U);
        check("mid_edit_up", 32'(work_value), 32'h0024);
        c0 = n_commit;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_work", 32'(work_value), 32'h0);
        check("arst_commit_val", 32'(commit_value), 32'h0);
        check("arst_edit", 32'(edit_mode), 32'h0);
        check("arst_cursor", 32'(cursor), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        check("arst_no_commit", 32'(n_commit), 32'(c0));
        press(C);
        check("post_rst_load", 32'(work_value), 32'h0);
        check("post_rst_edit", 32'(edit_mode), 32'h1);

        press(D);
        check("wrap_down", 32'(work_value), 32'h0009);
        press(U);
        check("wrap_up", 32'(work_value), 32'h0000);
        press(R);
        check("wrap_right", 32'(cursor), 32'h3);
        press(L); press(L); press(L); press(L);
        check("wrap_left4", 32'(cursor), 32'h3);
        check("wrap_neighbours", 32'(work_value), 32'h0000);

        press(U | L);
        check("simul_digit", 32'(work_value), 32'h1000);
        check("simul_cursor", 32'(cursor), 32'h3);
        c0 = n_commit;
        press(C | U);
        check("simul_commit_val", 32'(commit_value), 32'h1000);
        check("simul_no_inc", 32'(work_value), 32'h1000);
        check("simul_commit_cnt", 32'(n_commit), 32'(c0 + 1));
        check("simul_exit", 32'(edit_mode), 32'h0);

        press(C);
        check("held_enter_cursor", 32'(cursor), 32'h0);
        @(negedge clk) btns = U;
        @(posedge clk) #1 check("lat_k", 32'(work_value), 32'h1000);
        @(posedge clk) #1 check("lat_k1", 32'(work_value), 32'h1000);
        @(posedge clk) #1 check("lat_k2", 32'(work_value), 32'h1001);
        repeat (2000) @(negedge clk);
        check("held_one_inc", 32'(work_value), 32'h1001);
        btns = '0;
        repeat (4) @(negedge clk);

        btns = C;
        @(posedge clk) #1 check("strobe_k", 32'(commit), 32'h0);
        @(posedge clk) #1 check("strobe_k1", 32'(commit), 32'h0);
        @(posedge clk) #1;
        check("strobe_k2", 32'(commit), 32'h1);
        check("strobe_val", 32'(commit_value), 32'h1001);
        check("strobe_edit", 32'(edit_mode), 32'h0);
        @(posedge clk) #1 check("strobe_k3", 32'(commit), 32'h0);
        @(negedge clk) btns = '0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
